// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin, packet-locked arbiter that merges CHANNELS request streams onto one
// registered AXI4-Stream output; stream_tdest carries the source channel index.
module axis_rr_packet_arbiter #(
  parameter  int CHANNELS   = 5,
  parameter  int DATA_WIDTH = 128,
  parameter  int DEST_WIDTH = 32,
  localparam int CH_BITS    = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [CHANNELS-1:0]            ch_enable,
  input  logic [CHANNELS-1:0]            req_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] req_data,
  input  logic [CHANNELS-1:0]            req_last,
  output logic [CHANNELS-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]          stream_tdata,
  output logic [DEST_WIDTH-1:0]          stream_tdest,
  output logic                           stream_tlast,
  output logic                           stream_tvalid,
  input  logic                           stream_tready,
  output logic                           busy,
  output logic [CH_BITS-1:0]             grant_idx
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                r_state;
  logic [CH_BITS-1:0]    r_grant_idx;
  logic [CH_BITS-1:0]    r_last_index;
  logic                  r_busy;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [CH_BITS-1:0]    r_tdest;

  logic [DATA_WIDTH-1:0] w_ch_data [CHANNELS];
  logic [CHANNELS-1:0]   w_eligible;
  logic                  w_pick_valid;
  logic [CH_BITS-1:0]    w_pick_idx;
  logic [CH_BITS-1:0]    w_scan_idx;
  int                    w_scan;
  logic                  w_out_ready;
  logic                  w_accept;
  logic                  w_sel_last;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign w_ch_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_eligible = req_valid & ch_enable;

  // Scan last_index+1 .. last_index+CHANNELS, wrapping at CHANNELS rather than 2^CH_BITS.
  always_comb begin
    w_pick_valid = 1'b0;
    w_pick_idx   = '0;
    w_scan       = 0;
    w_scan_idx   = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      w_scan = int'(r_last_index) + k;
      if (w_scan >= CHANNELS) begin
        w_scan = w_scan - CHANNELS;
      end
      w_scan_idx = CH_BITS'(w_scan);
      if (!w_pick_valid && w_eligible[w_scan_idx]) begin
        w_pick_valid = 1'b1;
        w_pick_idx   = w_scan_idx;
      end
    end
  end

  assign w_out_ready = !r_tvalid || stream_tready;
  assign w_sel_last  = req_last[r_grant_idx];
  assign w_accept    = (r_state == ST_LOCKED) && req_valid[r_grant_idx] && w_out_ready;

  always_comb begin
    req_ready = '0;
    if (r_state == ST_LOCKED && w_out_ready) begin
      req_ready[r_grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_grant_idx  <= '0;
      r_last_index <= CH_BITS'(CHANNELS - 1);
      r_busy       <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_tdest      <= '0;
    end else begin
      // Output register: load on acceptance, otherwise drain when downstream takes it.
      if (w_accept) begin
        r_tdata  <= w_ch_data[r_grant_idx];
        r_tlast  <= w_sel_last;
        r_tdest  <= r_grant_idx;
        r_tvalid <= 1'b1;
      end else if (stream_tready) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_grant_idx <= w_pick_idx;
            r_busy      <= 1'b1;
            r_state     <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_accept && w_sel_last) begin
            r_last_index <= r_grant_idx;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stream_tdata  = r_tdata;
  assign stream_tdest  = DEST_WIDTH'(r_tdest);
  assign stream_tlast  = r_tlast;
  assign stream_tvalid = r_tvalid;
  assign busy          = r_busy;
  assign grant_idx     = r_grant_idx;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed bench for axis_rr_packet_arbiter: a 5-channel instance for the main scenarios
// and a 3-channel instance for the modulo-CHANNELS wrap.
module tb_axis_rr_packet_arbiter;

  logic         clk;
  logic         resetn;
  logic [4:0]   ch_enable;
  logic [4:0]   req_valid;
  logic [639:0] req_data;
  logic [4:0]   req_last;
  logic [4:0]   req_ready;
  logic [127:0] stream_tdata;
  logic [31:0]  stream_tdest;
  logic         stream_tlast;
  logic         stream_tvalid;
  logic         stream_tready;
  logic         busy;
  logic [2:0]   grant_idx;

  logic [2:0]   en3, v3, l3, rdy3;
  logic [23:0]  d3;
  logic [7:0]   td3;
  logic [3:0]   tdest3;
  logic         tl3, tv3, trdy3, busy3;
  logic [1:0]   g3;

  int total = 0;
  int bad   = 0;
  int tot  [5];
  int beat [5];
  int plen [5];
  int order [3] = '{1, 3, 4};
  int ph, pk, nrecv;
  logic p_v, p_r;

  axis_rr_packet_arbiter #(.CHANNELS(5), .DATA_WIDTH(128), .DEST_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .ch_enable(ch_enable), .req_valid(req_valid),
    .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .stream_tdata(stream_tdata), .stream_tdest(stream_tdest), .stream_tlast(stream_tlast),
    .stream_tvalid(stream_tvalid), .stream_tready(stream_tready), .busy(busy),
    .grant_idx(grant_idx)
  );

  axis_rr_packet_arbiter #(.CHANNELS(3), .DATA_WIDTH(8), .DEST_WIDTH(4)) dut3 (
    .clk(clk), .resetn(resetn), .ch_enable(en3), .req_valid(v3),
    .req_data(d3), .req_last(l3), .req_ready(rdy3),
    .stream_tdata(td3), .stream_tdest(tdest3), .stream_tlast(tl3),
    .stream_tvalid(tv3), .stream_tready(trdy3), .busy(busy3),
    .grant_idx(g3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel i presents data i*0x1000 + running beat count; last on the final beat of plen.
  task automatic drive_src();
    for (int i = 0; i < 5; i++) begin
      req_data[i*128 +: 128] = 128'(i * 4096 + tot[i]);
      req_last[i]            = (beat[i] == plen[i] - 1);
    end
  endtask

  task automatic step();
    logic [4:0] acc;
    #1;
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      if (acc[i]) begin
        tot[i]++;
        beat[i] = (beat[i] == plen[i] - 1) ? 0 : beat[i] + 1;
      end
    end
    drive_src();
  endtask

  initial begin
    resetn        = 1'b0;
    ch_enable     = 5'b00000;
    req_valid     = 5'b00000;
    req_data      = '0;
    req_last      = '0;
    stream_tready = 1'b1;
    en3 = 3'b000; v3 = 3'b000; l3 = 3'b000; d3 = '0; trdy3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tot[i] = 0; beat[i] = 0; plen[i] = 1;
    end
    tot[0] = 'hA5;
    drive_src();

    // Reset state
    #3;
    chk("rst_tvalid", stream_tvalid, 0);
    chk("rst_tdata", stream_tdata, 0);
    chk("rst_tdest", stream_tdest, 0);
    chk("rst_tlast", stream_tlast, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 0);
    #9 resetn = 1'b1;

    // Single-beat packet from channel 0: ready at cycle 1, beat on stream at cycle 2
    ch_enable = 5'b11111;
    req_valid = 5'b00001;
    drive_src();
    #1;
    chk("t1_idle_ready", req_ready, 5'b00000);
    step();
    chk("t1_ready_c1", req_ready, 5'b00001);
    chk("t1_busy_c1", busy, 1);
    chk("t1_tvalid_c1", stream_tvalid, 0);
    step();
    chk("t1_tvalid_c2", stream_tvalid, 1);
    chk("t1_tdata_c2", stream_tdata, 'hA5);
    chk("t1_tdest_c2", stream_tdest, 0);
    chk("t1_tlast_c2", stream_tlast, 1);
    chk("t1_busy_c2", busy, 0);
    req_valid = 5'b00000;
    step();
    chk("t1_tvalid_c3", stream_tvalid, 0);

    // Channels 1,3,4 with continuous 2-beat packets: order 1,3,4,1,3,4 with one bubble
    plen[1] = 2; plen[3] = 2; plen[4] = 2;
    req_valid = 5'b11010;
    drive_src();
    step();
    chk("t2_ready_c1", req_ready, 5'b00010);
    step();
    for (int c = 2; c <= 18; c++) begin
      ph = (c - 2) % 3;
      pk = (c - 2) / 3;
      if (ph == 2) begin
        chk("t2_bubble", stream_tvalid, 0);
      end else begin
        chk("t2_tvalid", stream_tvalid, 1);
        chk("t2_tdest", stream_tdest, order[pk % 3]);
        chk("t2_tlast", stream_tlast, (ph == 1));
        chk("t2_tdata", stream_tdata, order[pk % 3] * 4096 + 2 * (pk / 3) + ph);
      end
      if (c == 18) req_valid = 5'b00000;
      else step();
    end
    step();

    // Channel 2, 4-beat packet under tready pattern 1,0,0,1
    plen[2] = 4;
    req_valid = 5'b00100;
    drive_src();
    nrecv = 0;
    for (int c = 0; c < 40 && nrecv < 4; c++) begin
      stream_tready = (c % 4 == 0) || (c % 4 == 3);
      p_v = stream_tvalid;
      p_r = stream_tready;
      step();
      if (p_v && p_r) begin
        nrecv++;
      end else if (p_v) begin
        chk("t3_hold_tvalid", stream_tvalid, 1);
      end
      if (stream_tvalid && nrecv < 4) begin
        chk("t3_tdata", stream_tdata, 2 * 4096 + nrecv);
        chk("t3_tlast", stream_tlast, (nrecv == 3));
      end
      if (tot[2] == 4) req_valid[2] = 1'b0;
    end
    chk("t3_beats_recv", nrecv, 4);
    stream_tready = 1'b1;
    step();
    chk("t3_drained", stream_tvalid, 0);

    // Channel 0 mid-packet: ch4 requests, ch0 disabled -> ch0 completes, ch4 next, no ch0 regrant
    plen[0] = 3; plen[4] = 1;
    req_valid = 5'b00001;
    drive_src();
    step();
    chk("t4_ready_c1", req_ready, 5'b00001);
    step();
    chk("t4_tdata_b0", stream_tdata, 'hA6);
    req_valid = 5'b10001;
    ch_enable = 5'b11110;
    step();
    chk("t4_ready_held", req_ready, 5'b00001);
    chk("t4_tdest_b1", stream_tdest, 0);
    chk("t4_tdata_b1", stream_tdata, 'hA7);
    step();
    chk("t4_tdata_b2", stream_tdata, 'hA8);
    chk("t4_tlast_b2", stream_tlast, 1);
    chk("t4_busy_idle", busy, 0);
    step();
    chk("t4_grant4", grant_idx, 4);
    chk("t4_busy4", busy, 1);
    step();
    chk("t4_tdest4", stream_tdest, 4);
    chk("t4_tdata4", stream_tdata, 4 * 4096 + 4);
    chk("t4_single_lock", busy, 0);
    req_valid = 5'b00001;
    step();
    chk("t4_no_regrant_a", busy, 0);
    step();
    chk("t4_no_regrant_b", busy, 0);
    chk("t4_grant_kept", grant_idx, 4);
    req_valid = 5'b00000;
    ch_enable = 5'b11111;
    step();

    // Asynchronous reset mid-packet, then 0 beats 2 on simultaneous requests
    plen[0] = 3;
    req_valid = 5'b00001;
    drive_src();
    step();
    step();
    chk("t5_pre_tvalid", stream_tvalid, 1);
    #3 resetn = 1'b0;
    #1;
    chk("t5_rst_tvalid", stream_tvalid, 0);
    chk("t5_rst_tdata", stream_tdata, 0);
    chk("t5_rst_tlast", stream_tlast, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", req_ready, 0);
    for (int i = 0; i < 5; i++) beat[i] = 0;
    plen[0] = 1; plen[2] = 1;
    req_valid = 5'b00101;
    drive_src();
    #2 resetn = 1'b1;
    step();
    chk("t5_first_grant", grant_idx, 0);
    chk("t5_first_busy", busy, 1);
    step();
    chk("t5_tdest0", stream_tdest, 0);
    chk("t5_tdata0", stream_tdata, 'hAA);
    req_valid[0] = 1'b0;
    step();
    chk("t5_second_grant", grant_idx, 2);
    step();
    chk("t5_tdest2", stream_tdest, 2);
    chk("t5_tdata2", stream_tdata, 2 * 4096 + 4);
    req_valid = 5'b00000;
    step();

    // 3-channel instance: after ch2, requests from 0 and 1 pick 0 (modulo-3 wrap)
    en3 = 3'b111; l3 = 3'b111; d3 = {8'h12, 8'h11, 8'h10};
    v3 = 3'b100;
    step();
    chk("t6_grant2", g3, 2);
    step();
    chk("t6_tdest2", tdest3, 2);
    v3 = 3'b011;
    step();
    chk("t6_wrap_grant0", g3, 0);
    chk("t6_ready0", rdy3, 3'b001);
    step();
    chk("t6_tdata0", td3, 8'h10);
    chk("t6_tdest0", tdest3, 0);
    v3 = 3'b010;
    step();
    chk("t6_grant1", g3, 1);
    step();
    chk("t6_tdest1", tdest3, 1);
    chk("t6_tdata1", td3, 8'h11);
    v3 = 3'b000;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- Shares the single AXI4-Stream output of the AXI-to-stream bridge among CHANNELS capture submodules (AR, AW, W, R, B).
- Selects requesters in round-robin order and locks the grant for a whole packet, until the beat carrying req_last is accepted.
- Drives the stream through a registered output stage.
- Tags every beat with the source channel index on stream_tdest.

Parameters:
- CHANNELS, 5, number of requesting submodules (2..16).
- DATA_WIDTH, 128, stream data width in bits.
- DEST_WIDTH, 32, stream_tdest width; must be at least $clog2(CHANNELS).
- CH_BITS, $clog2(CHANNELS), localparam, width of a channel index.

Ports:
- clk  in  1  clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- ch_enable  in  CHANNELS  per-channel arbitration enable mask.
- req_valid  in  CHANNELS  channel i has a beat available.
- req_data  in  CHANNELS*DATA_WIDTH  beat data; channel i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  CHANNELS  beat is the last of the packet.
- req_ready  out  CHANNELS  beat accepted from channel i when req_valid[i]&&req_ready[i].
- stream_tdata  out  DATA_WIDTH  registered output data.
- stream_tdest  out  DEST_WIDTH  source channel index, zero-extended.
- stream_tlast  out  1  registered end-of-packet.
- stream_tvalid  out  1  output beat valid.
- stream_tready  in  1  downstream ready.
- busy  out  1  arbiter in LOCKED state.
- grant_idx  out  CH_BITS  currently or most recently granted channel.

Behaviour:
- Reset (asynchronous, resetn=0):
  - State IDLE.
  - stream_tvalid=0, stream_tdata=0, stream_tlast=0, stream_tdest=0.
  - req_ready=0, busy=0, grant_idx=0.
  - last_index=CHANNELS-1, so channel 0 has first priority.
- Reset asserted mid-packet aborts immediately:
  - The output register is cleared.
  - The partial packet is dropped; no stream_tlast is emitted.
- State IDLE:
  - req_ready is all zero.
  - Eligible channel: req_valid[i]&&ch_enable[i].
  - If any channel is eligible, pick the first eligible index scanning last_index+1, last_index+2, ..., wrapping modulo CHANNELS (not modulo 2^CH_BITS).
  - On a pick: register grant_idx, set busy=1, go to LOCKED on the next edge.
  - If no channel is eligible, stay in IDLE.
- State LOCKED:
  - Only req_ready[grant_idx] may be 1; all other bits are 0.
  - req_ready[grant_idx] = !stream_tvalid || stream_tready.
  - On acceptance: stream_tdata<=req_data[grant_idx], stream_tlast<=req_last[grant_idx], stream_tdest<=grant_idx, stream_tvalid<=1.
  - If the accepted beat has req_last=1: go to IDLE, set last_index<=grant_idx, busy<=0.
- Output register:
  - stream_tvalid clears when stream_tready=1 and no new beat loads in the same cycle.
  - stream_tdata, stream_tlast and stream_tdest hold stable while stream_tvalid&&!stream_tready.
- Latency:
  - Request seen in IDLE at cycle 0, req_ready high at cycle 1, beat on stream at cycle 2.
  - Within a packet with stream_tready=1: one beat per cycle.
  - Between packets: exactly one arbitration bubble cycle on the input side.
- Granted channel drops req_valid mid-packet: the grant is held indefinitely (no timeout); other channels wait.
- ch_enable[grant_idx] deasserted mid-packet: the packet completes; the mask affects only the next arbitration.
- Simultaneous events:
  - A last-beat acceptance and new requests in the same cycle: the new requests are evaluated in the following IDLE cycle, using the updated last_index.
- Single-beat packet (req_last=1 on the first beat): LOCKED lasts one cycle.
- Valids on non-granted channels never assert their req_ready; their data is ignored.

Test Plan:
- Reset, then ch_enable=5'b11111 and req_valid[0]=1 with a 1-beat packet (data 0xA5, last=1) -> req_ready[0]=1 at cycle 1; stream_tvalid=1, tdata=0xA5, tdest=0, tlast=1 at cycle 2.
- Channels 1, 3 and 4 each request continuously with 2-beat packets, stream_tready=1 -> packets emitted in order tdest 1,3,4,1,3,4; no interleaving; 1 idle cycle between packets.
- Channel 2 sends a 4-beat packet; stream_tready toggles 1,0,0,1,... -> no beat lost or duplicated; data held stable while stalled; tlast on the 4th beat only.
- Channel 0 granted and mid-packet (beat 2 of 3); channel 4 asserts valid and channel 0's ch_enable drops -> channel 0 finishes all 3 beats; channel 4 is granted next; channel 0 is not re-granted while disabled.
- Assert resetn=0 asynchronously (between clock edges) mid-packet -> all outputs 0 immediately; after release, channel 0 wins first among simultaneous requests 0 and 2.
- CHANNELS=3 with last_index=2 and requests from 0 and 1 -> channel 0 is chosen (modulo-3 wrap; index 3 is never produced).
